// File: rtl/stove_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : stove_pkg                                              |
// | Purpose : Shared types and constants for the multi-surface stove |
// |           controller: controller state encoding and the          |
// |           active-low 7-segment digit table {dp,g,f,e,d,c,b,a}.   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package stove_pkg;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  // Every segment dark, decimal point included.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low digits 0..9 with the decimal point dark (bit 7 = 1).
  // Listed from index 9 down to index 0.
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    if (d <= 4'd9) return SEG_DIGITS[d];
    return SEG_BLANK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : input_conditioner                                      |
// | Purpose : Conditions one raw push button: 2-FF synchronizer,     |
// |           debouncer, rising-edge detector. Each press yields a   |
// |           single 1-cycle pulse DEBOUNCE_CYCLES+3 cycles after    |
// |           the raw input rises.                                   |
// | Ports   : clk, async_reset (active low), raw (button),           |
// |           pulse (1-cycle press event)                            |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic async_reset,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic          armed;
  logic [CW-1:0] cnt;

  // The synchronizer resets to "pressed" and the edge detector stays
  // disarmed until a released sample is seen. A button held through
  // reset therefore never produces an event until it is released and
  // pressed again.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      armed    <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // The debounced value flips on the DEBOUNCE_CYCLES-th
      // consecutive differing sample; any agreeing sample restarts.
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      stable_d <= stable;
      if (!sync2) armed <= 1'b1;
      pulse <= armed & stable & ~stable_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_surface_stove.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : multi_surface_stove                                    |
// | Purpose : Multi-surface stove controller. Conditions all push    |
// |           buttons, keeps one selectable power level per surface, |
// |           drives one registered 7-segment byte per surface and   |
// |           switches itself off after an idle timeout.             |
// | Ports   : clk, async_reset (async, active low), power_toggle,    |
// |           surface_toggle[N], power_level_inc, power_level_dec,   |
// |           power_level_7seg_output[8N] (byte i = surface i),      |
// |           stove_on, auto_off_event (1-cycle pulse)               |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module multi_surface_stove
  import stove_pkg::*;
#(
  parameter int NUM_SURFACES        = 4,
  parameter int MAX_LEVEL           = 9,
  parameter int DEBOUNCE_CYCLES     = 16,
  parameter int IDLE_TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      async_reset,
  input  logic                      power_toggle,
  input  logic [NUM_SURFACES-1:0]   surface_toggle,
  input  logic                      power_level_inc,
  input  logic                      power_level_dec,
  output logic [8*NUM_SURFACES-1:0] power_level_7seg_output,
  output logic                      stove_on,
  output logic                      auto_off_event
);

  localparam int LW = $clog2(MAX_LEVEL + 1);
  localparam int SW = (NUM_SURFACES > 1) ? $clog2(NUM_SURFACES) : 1;
  localparam int TW = (IDLE_TIMEOUT_CYCLES > 1) ? $clog2(IDLE_TIMEOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LV_MAX    = LW'(MAX_LEVEL);
  localparam logic [TW-1:0] TIMER_END = TW'(IDLE_TIMEOUT_CYCLES - 1);

  // Conditioned one-cycle events
  logic                    pwr_ev;
  logic                    inc_ev;
  logic                    dec_ev;
  logic [NUM_SURFACES-1:0] surf_ev;

  input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_pwr (
    .clk(clk), .async_reset(async_reset), .raw(power_toggle), .pulse(pwr_ev));
  input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_inc (
    .clk(clk), .async_reset(async_reset), .raw(power_level_inc), .pulse(inc_ev));
  input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_dec (
    .clk(clk), .async_reset(async_reset), .raw(power_level_dec), .pulse(dec_ev));

  for (genvar g = 0; g < NUM_SURFACES; g++) begin : g_surf_cond
    input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_surf (
      .clk(clk), .async_reset(async_reset), .raw(surface_toggle[g]), .pulse(surf_ev[g]));
  end

  // Controller state
  state_t                  state_q, state_n;
  logic                    sel_valid_q, sel_valid_n;
  logic [SW-1:0]           sel_idx_q, sel_idx_n;
  logic [LW-1:0]           level_q [NUM_SURFACES];
  logic [LW-1:0]           level_n [NUM_SURFACES];
  logic [TW-1:0]           timer_q, timer_n;
  logic                    auto_off_n;
  logic [8*NUM_SURFACES-1:0] disp_n;

  logic          all_zero;
  logic          any_ev;
  logic          timeout;
  logic          found;
  logic [SW-1:0] hit_idx;

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NUM_SURFACES; i++) begin
      if (level_q[i] != '0) all_zero = 1'b0;
    end
  end

  assign any_ev  = pwr_ev | inc_ev | dec_ev | (|surf_ev);
  assign timeout = (state_q == ST_ON) && all_zero && (timer_q == TIMER_END);

  // Lowest-index surface event wins.
  always_comb begin
    found   = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_SURFACES; i++) begin
      if (surf_ev[i] && !found) begin
        found   = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  always_comb begin
    state_n     = state_q;
    sel_valid_n = sel_valid_q;
    sel_idx_n   = sel_idx_q;
    level_n     = level_q;
    timer_n     = '0;
    auto_off_n  = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (pwr_ev) state_n = ST_ON;
      end
      ST_ON: begin
        if (pwr_ev || timeout) begin
          // A power event beats the timeout, so no auto-off pulse then.
          state_n     = ST_OFF;
          sel_valid_n = 1'b0;
          sel_idx_n   = '0;
          auto_off_n  = !pwr_ev;
          for (int i = 0; i < NUM_SURFACES; i++) level_n[i] = '0;
        end else begin
          if (found) begin
            if (sel_valid_q && (sel_idx_q == hit_idx)) begin
              sel_valid_n = 1'b0;
            end else begin
              sel_valid_n = 1'b1;
              sel_idx_n   = hit_idx;
            end
          end
          // inc/dec act on the selection as updated this same cycle.
          if (sel_valid_n && (inc_ev ^ dec_ev)) begin
            if (inc_ev && (level_q[sel_idx_n] != LV_MAX))
              level_n[sel_idx_n] = level_q[sel_idx_n] + 1'b1;
            else if (dec_ev && (level_q[sel_idx_n] != '0))
              level_n[sel_idx_n] = level_q[sel_idx_n] - 1'b1;
          end
          if (all_zero && !any_ev) timer_n = timer_q + 1'b1;
        end
      end
      default: state_n = ST_OFF;
    endcase
  end

  // Display image built from the current registers; it is registered
  // below, so it trails the level/selection registers by one cycle.
  always_comb begin
    disp_n = '1;
    for (int i = 0; i < NUM_SURFACES; i++) begin
      if (state_q == ST_ON) begin
        disp_n[8*i +: 8] = seg_digit(4'(level_q[i]));
        disp_n[8*i + 7]  = ~(sel_valid_q && (sel_idx_q == SW'(i)));
      end
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q                 <= ST_OFF;
      sel_valid_q             <= 1'b0;
      sel_idx_q               <= '0;
      timer_q                 <= '0;
      auto_off_event          <= 1'b0;
      power_level_7seg_output <= '1;
      for (int i = 0; i < NUM_SURFACES; i++) level_q[i] <= '0;
    end else begin
      state_q                 <= state_n;
      sel_valid_q             <= sel_valid_n;
      sel_idx_q               <= sel_idx_n;
      timer_q                 <= timer_n;
      auto_off_event          <= auto_off_n;
      power_level_7seg_output <= disp_n;
      for (int i = 0; i < NUM_SURFACES; i++) level_q[i] <= level_n[i];
    end
  end

  assign stove_on = (state_q == ST_ON);

endmodule
`default_nettype wire
